// File: rtl/l1_trigger_collector.sv
// Merges masked L1 beam triggers into timestamped events, applies a global holdoff,
// and queues the events in a first-word-fall-through FIFO toward readout.
module l1_trigger_collector #(
  parameter int NBEAMS         = 2,
  parameter int MERGE_CLOCKS   = 4,
  parameter int HOLDOFF_CLOCKS = 16,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NBEAMS-1:0]             trig_i,
  input  logic [NBEAMS-1:0]             beam_en_i,
  input  logic                          enable_i,
  input  logic                          clear_drops_i,
  output logic                          trig_valid_o,
  input  logic                          trig_ready_i,
  output logic [NBEAMS-1:0]             trig_beams_o,
  output logic [31:0]                   trig_time_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [15:0]                   dropped_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = NBEAMS + 32;

  typedef enum logic [1:0] {IDLE, MERGE, PUSH, HOLDOFF} state_t;

  state_t            state_q, state_d;
  logic [31:0]       ts_q;
  logic [31:0]       ev_time_q, ev_time_d;
  logic [NBEAMS-1:0] ev_beams_q, ev_beams_d;
  logic [31:0]       mcnt_q, mcnt_d;
  logic [31:0]       hcnt_q, hcnt_d;
  logic [NBEAMS-1:0] masked;
  logic              push_req;

  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [15:0]       dropped_q;
  logic              full, empty, push, pop;
  logic [EW-1:0]     head;

  assign masked = trig_i & beam_en_i;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ts_q       <= '0;
      state_q    <= IDLE;
      ev_time_q  <= '0;
      ev_beams_q <= '0;
      mcnt_q     <= '0;
      hcnt_q     <= '0;
    end else begin
      ts_q       <= ts_q + 32'd1;
      state_q    <= state_d;
      ev_time_q  <= ev_time_d;
      ev_beams_q <= ev_beams_d;
      mcnt_q     <= mcnt_d;
      hcnt_q     <= hcnt_d;
    end
  end

  // Once an event has started, enable_i no longer matters; only the counters decide.
  always_comb begin
    state_d    = state_q;
    ev_time_d  = ev_time_q;
    ev_beams_d = ev_beams_q;
    mcnt_d     = mcnt_q;
    hcnt_d     = hcnt_q;
    push_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && (|masked)) begin
          ev_time_d  = ts_q;
          ev_beams_d = masked;
          mcnt_d     = 32'(MERGE_CLOCKS - 1);
          state_d    = (MERGE_CLOCKS == 1) ? PUSH : MERGE;
        end
      end
      MERGE: begin
        ev_beams_d = ev_beams_q | masked;
        mcnt_d     = mcnt_q - 32'd1;
        if (mcnt_q == 32'd1) state_d = PUSH;
      end
      PUSH: begin
        push_req = 1'b1;
        hcnt_d   = 32'(HOLDOFF_CLOCKS);
        state_d  = (HOLDOFF_CLOCKS == 0) ? IDLE : HOLDOFF;
      end
      HOLDOFF: begin
        hcnt_d = hcnt_q - 32'd1;
        if (hcnt_q == 32'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fullness uses the registered count, so a same-cycle pop never makes room for a push.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = push_req && !full;
  assign pop   = trig_ready_i && !empty;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q] <= {ev_beams_q, ev_time_q};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A clear pulse takes priority over a drop in the same cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dropped_q <= '0;
    end else if (clear_drops_i) begin
      dropped_q <= '0;
    end else if (push_req && full && (dropped_q != 16'hFFFF)) begin
      dropped_q <= dropped_q + 16'd1;
    end
  end

  assign head         = mem[rd_ptr_q];
  assign trig_valid_o = !empty;
  assign trig_beams_o = empty ? '0 : head[EW-1:32];
  assign trig_time_o  = empty ? '0 : head[31:0];
  assign fifo_count_o = count_q;
  assign dropped_o    = dropped_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_l1_trigger_collector.sv
// Directed-vector bench for l1_trigger_collector at default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_l1_trigger_collector;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  trig_i;
  logic [1:0]  beam_en_i;
  logic        enable_i;
  logic        clear_drops_i;
  logic        trig_valid_o;
  logic        trig_ready_i;
  logic [1:0]  trig_beams_o;
  logic [31:0] trig_time_o;
  logic [4:0]  fifo_count_o;
  logic [15:0] dropped_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] tb_ts;
  logic [31:0] ev_times [17];
  logic [1:0]  ev_beams [17];

  l1_trigger_collector dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trig_i        (trig_i),
    .beam_en_i     (beam_en_i),
    .enable_i      (enable_i),
    .clear_drops_i (clear_drops_i),
    .trig_valid_o  (trig_valid_o),
    .trig_ready_i  (trig_ready_i),
    .trig_beams_o  (trig_beams_o),
    .trig_time_o   (trig_time_o),
    .fifo_count_o  (fifo_count_o),
    .dropped_o     (dropped_o),
    .busy_o        (busy_o)
  );

  always #5 aclk = ~aclk;

  // Reference timestamp: restarts at 0 on reset and counts every rising edge.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) tb_ts <= '0;
    else          tb_ts <= tb_ts + 32'd1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      @(negedge aclk);
      n++;
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wait_idle: busy_o=%b, want 0 within 100 cycles", busy_o);
    end
  endtask

  task automatic wait_ts(input logic [31:0] target);
    int n = 0;
    while (tb_ts != target && n < 2000) begin
      @(negedge aclk);
      n++;
    end
  endtask

  task automatic fire(input logic [1:0] pat);
    trig_i = pat;
    tick(1);
    trig_i = 2'b00;
    wait_idle();
  endtask

  task automatic test_reset();
    tick(2);
    vectors++; if (trig_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b want 0", trig_valid_o); end
    vectors++; if (trig_beams_o !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_beams: got %b want 00", trig_beams_o); end
    vectors++; if (trig_time_o !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_time: got %0d want 0", trig_time_o); end
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", fifo_count_o); end
    vectors++; if (dropped_o !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_dropped: got %0d want 0", dropped_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    aresetn = 1'b1;
  endtask

  task automatic test_single_beam();
    trig_ready_i = 1'b1;
    wait_ts(32'd100);
    trig_i = 2'b01;
    tick(1);
    trig_i = 2'b00;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy: got %b want 1", busy_o); end
    tick(3);
    vectors++; if (trig_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL single_valid_early: got %b want 0", trig_valid_o); end
    tick(1);
    vectors++; if (trig_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL single_valid: got %b want 1", trig_valid_o); end
    vectors++; if (trig_beams_o !== 2'b01) begin miscompares++; $display("[TB] FAIL single_beams: got %b want 01", trig_beams_o); end
    vectors++; if (trig_time_o !== 32'd100) begin miscompares++; $display("[TB] FAIL single_time: got %0d want 100", trig_time_o); end
    vectors++; if (fifo_count_o !== 5'd1) begin miscompares++; $display("[TB] FAIL single_count: got %0d want 1", fifo_count_o); end
    tick(1);
    vectors++; if (trig_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL single_popped_valid: got %b want 0", trig_valid_o); end
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL single_popped_count: got %0d want 0", fifo_count_o); end
    wait_idle();
    trig_ready_i = 1'b0;
  endtask

  task automatic test_merge();
    logic [31:0] t0;
    t0 = tb_ts;
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00;
    tick(2); trig_i = 2'b10;
    tick(1); trig_i = 2'b10;
    tick(1);
    vectors++; if (fifo_count_o !== 5'd1) begin miscompares++; $display("[TB] FAIL merge_count1: got %0d want 1", fifo_count_o); end
    vectors++; if (trig_beams_o !== 2'b11) begin miscompares++; $display("[TB] FAIL merge_beams: got %b want 11", trig_beams_o); end
    vectors++; if (trig_time_o !== t0) begin miscompares++; $display("[TB] FAIL merge_time: got %0d want %0d", trig_time_o, t0); end
    trig_i = 2'b11;
    tick(15);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL merge_holdoff_busy: got %b want 1", busy_o); end
    tick(1);
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL merge_idle_at_21: got %b want 0", busy_o); end
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00;
    wait_idle();
    vectors++; if (fifo_count_o !== 5'd2) begin miscompares++; $display("[TB] FAIL merge_count2: got %0d want 2", fifo_count_o); end
    trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
    vectors++; if (fifo_count_o !== 5'd1) begin miscompares++; $display("[TB] FAIL merge_pop_count: got %0d want 1", fifo_count_o); end
    vectors++; if (trig_beams_o !== 2'b01) begin miscompares++; $display("[TB] FAIL merge_ev2_beams: got %b want 01", trig_beams_o); end
    vectors++; if (trig_time_o !== t0 + 32'd21) begin miscompares++; $display("[TB] FAIL merge_ev2_time: got %0d want %0d", trig_time_o, t0 + 32'd21); end
    trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
    vectors++; if (trig_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL merge_drained: got %b want 0", trig_valid_o); end
  endtask

  task automatic test_masking();
    beam_en_i = 2'b10;
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mask_busy: got %b want 0", busy_o); end
    tick(6);
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL mask_count: got %0d want 0", fifo_count_o); end
    beam_en_i = 2'b11;
    enable_i = 1'b0;
    trig_i = 2'b11;
    tick(1); trig_i = 2'b00;
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL disable_busy: got %b want 0", busy_o); end
    tick(6);
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL disable_count: got %0d want 0", fifo_count_o); end
    enable_i = 1'b1;
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00; enable_i = 1'b0;
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL enable_drop_busy: got %b want 1", busy_o); end
    tick(4);
    vectors++; if (fifo_count_o !== 5'd1) begin miscompares++; $display("[TB] FAIL enable_drop_count: got %0d want 1", fifo_count_o); end
    vectors++; if (trig_beams_o !== 2'b01) begin miscompares++; $display("[TB] FAIL enable_drop_beams: got %b want 01", trig_beams_o); end
    wait_idle();
    enable_i = 1'b1;
    trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL enable_drop_drain: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      ev_beams[i] = 2'(i % 3 + 1);
      ev_times[i] = tb_ts;
      fire(ev_beams[i]);
    end
    vectors++; if (fifo_count_o !== 5'd16) begin miscompares++; $display("[TB] FAIL ovf_count: got %0d want 16", fifo_count_o); end
    vectors++; if (dropped_o !== 16'd1) begin miscompares++; $display("[TB] FAIL ovf_dropped: got %0d want 1", dropped_o); end
    vectors++; if (trig_time_o !== ev_times[0]) begin miscompares++; $display("[TB] FAIL ovf_head_time: got %0d want %0d", trig_time_o, ev_times[0]); end
    clear_drops_i = 1'b1; tick(1); clear_drops_i = 1'b0;
    vectors++; if (dropped_o !== 16'd0) begin miscompares++; $display("[TB] FAIL ovf_clear: got %0d want 0", dropped_o); end
  endtask

  task automatic test_saturation();
    force dut.dropped_q = 16'hFFFE;
    tick(1);
    release dut.dropped_q;
    fire(2'b01);
    vectors++; if (dropped_o !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_reach: got %h want ffff", dropped_o); end
    fire(2'b10);
    vectors++; if (dropped_o !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_hold: got %h want ffff", dropped_o); end
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00;
    tick(3); clear_drops_i = 1'b1;
    tick(1); clear_drops_i = 1'b0;
    vectors++; if (dropped_o !== 16'd0) begin miscompares++; $display("[TB] FAIL clear_wins: got %h want 0000", dropped_o); end
    wait_idle();
    vectors++; if (fifo_count_o !== 5'd16) begin miscompares++; $display("[TB] FAIL sat_count: got %0d want 16", fifo_count_o); end
  endtask

  task automatic test_drain();
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00;
    tick(3); trig_ready_i = 1'b1;
    tick(1); trig_ready_i = 1'b0;
    vectors++; if (fifo_count_o !== 5'd15) begin miscompares++; $display("[TB] FAIL full_pop_count: got %0d want 15", fifo_count_o); end
    vectors++; if (dropped_o !== 16'd1) begin miscompares++; $display("[TB] FAIL full_pop_dropped: got %0d want 1", dropped_o); end
    for (int i = 1; i < 16; i++) begin
      vectors++; if (trig_time_o !== ev_times[i]) begin miscompares++; $display("[TB] FAIL drain_time[%0d]: got %0d want %0d", i, trig_time_o, ev_times[i]); end
      vectors++; if (trig_beams_o !== ev_beams[i]) begin miscompares++; $display("[TB] FAIL drain_beams[%0d]: got %b want %b", i, trig_beams_o, ev_beams[i]); end
      trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
    end
    vectors++; if (trig_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL drain_empty_valid: got %b want 0", trig_valid_o); end
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL drain_empty_count: got %0d want 0", fifo_count_o); end
    trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL empty_pop_count: got %0d want 0", fifo_count_o); end
    wait_idle();
  endtask

  task automatic test_wrap();
    force dut.ts_q = 32'hFFFF_FFFE;
    tick(1);
    release dut.ts_q;
    tick(1);
    trig_i = 2'b01;
    tick(1); trig_i = 2'b00;
    vectors++; if (dut.ts_q !== 32'd0) begin miscompares++; $display("[TB] FAIL ts_wrap: got %h want 0", dut.ts_q); end
    tick(20);
    vectors++; if (trig_time_o !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL wrap_time: got %h want ffffffff", trig_time_o); end
    trig_i = 2'b10;
    tick(1); trig_i = 2'b00;
    tick(3); trig_ready_i = 1'b1;
    tick(1); trig_ready_i = 1'b0;
    vectors++; if (fifo_count_o !== 5'd1) begin miscompares++; $display("[TB] FAIL pushpop_count: got %0d want 1", fifo_count_o); end
    vectors++; if (trig_time_o !== 32'd20) begin miscompares++; $display("[TB] FAIL pushpop_time: got %0d want 20", trig_time_o); end
    vectors++; if (trig_beams_o !== 2'b10) begin miscompares++; $display("[TB] FAIL pushpop_beams: got %b want 10", trig_beams_o); end
    wait_idle();
    trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_merge();
    fire(2'b01);
    trig_i = 2'b11;
    tick(1); trig_i = 2'b00;
    tick(1);
    aresetn = 1'b0;
    #1;
    vectors++; if (trig_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_valid: got %b want 0", trig_valid_o); end
    vectors++; if (trig_beams_o !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_mid_beams: got %b want 00", trig_beams_o); end
    vectors++; if (trig_time_o !== 32'd0) begin miscompares++; $display("[TB] FAIL rst_mid_time: got %0d want 0", trig_time_o); end
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL rst_mid_count: got %0d want 0", fifo_count_o); end
    vectors++; if (dropped_o !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_mid_dropped: got %0d want 0", dropped_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy_o); end
    tick(1);
    aresetn = 1'b1;
    tick(6);
    vectors++; if (fifo_count_o !== 5'd0) begin miscompares++; $display("[TB] FAIL rst_no_event: got %0d want 0", fifo_count_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_idle: got %b want 0", busy_o); end
    wait_ts(32'd10);
    trig_i = 2'b10;
    tick(1); trig_i = 2'b00;
    tick(4);
    vectors++; if (trig_valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_new_valid: got %b want 1", trig_valid_o); end
    vectors++; if (trig_time_o !== 32'd10) begin miscompares++; $display("[TB] FAIL rst_new_time: got %0d want 10", trig_time_o); end
    vectors++; if (trig_beams_o !== 2'b10) begin miscompares++; $display("[TB] FAIL rst_new_beams: got %b want 10", trig_beams_o); end
    trig_ready_i = 1'b1; tick(1); trig_ready_i = 1'b0;
    wait_idle();
  endtask

  initial begin
    aresetn       = 1'b0;
    trig_i        = 2'b00;
    beam_en_i     = 2'b11;
    enable_i      = 1'b1;
    clear_drops_i = 1'b0;
    trig_ready_i  = 1'b0;
    test_reset();
    test_single_beam();
    test_merge();
    test_masking();
    test_overflow();
    test_saturation();
    test_drain();
    test_wrap();
    test_reset_mid_merge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
